// File: rtl/ring_ptr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ring_ptr_pkg
//  Description : Shared constants, helpers and types for the ring pointer
//                controller: default slot-index width and slot count, the
//                occupancy-counter width rule used by the wrap/distance
//                arithmetic, and the per-cycle update selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package ring_ptr_pkg;

    // Default slot-index width and ring slot count.
    localparam int RING_DEFAULT_NBITS = 2;
    localparam int RING_DEFAULT_SIZE  = 4;

    // Occupancy and modular-distance arithmetic use one extra bit so a
    // completely full ring (count == SIZE == 2^NBITS) is representable and
    // no result relies on natural power-of-two wrap.
    function automatic int ring_cnt_width(input int nbits);
        return nbits + 1;
    endfunction

    // Which register-update path is taken in a given cycle.
    typedef enum logic [1:0] {
        RING_OP_HOLD     = 2'd0,
        RING_OP_STEP     = 2'd1,   // alloc and/or free fire
        RING_OP_ROLLBACK = 2'd2,   // truncate younger slots (+ optional free)
        RING_OP_FLUSH    = 2'd3    // drop every occupied slot
    } ring_op_e;

endpackage : ring_ptr_pkg
`default_nettype wire

// File: rtl/ring_wrap_step.sv
`default_nettype none
// ============================================================================
//  Module      : ring_wrap_step
//  Description : Single-step modular pointer advance for a ring of SIZE slots
//                (SIZE need not be a power of two).
//                UP=1 : o_val = (i_val == SIZE-1) ? 0      : i_val + 1
//                UP=0 : o_val = (i_val == 0)      ? SIZE-1 : i_val - 1
//  Ports       : i_val [NBITS-1:0]  pointer to step
//                o_val [NBITS-1:0]  stepped pointer (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_wrap_step
    import ring_ptr_pkg::*;
#(
    parameter int NBITS = RING_DEFAULT_NBITS,
    parameter int SIZE  = RING_DEFAULT_SIZE,
    parameter bit UP    = 1'b1
) (
    input  logic [NBITS-1:0] i_val,
    output logic [NBITS-1:0] o_val
);

    localparam logic [NBITS-1:0] c_last = NBITS'(SIZE - 1);
    localparam logic [NBITS-1:0] c_zero = '0;
    localparam logic [NBITS-1:0] c_one  = NBITS'(1);

    generate
        if (UP) begin : g_up
            // i_val + 1 cannot overflow NBITS bits unless i_val == SIZE-1,
            // which is caught explicitly.
            assign o_val = (i_val == c_last) ? c_zero : (i_val + c_one);
        end else begin : g_down
            assign o_val = (i_val == c_zero) ? c_last : (i_val - c_one);
        end
    endgenerate

endmodule : ring_wrap_step
`default_nettype wire

// File: rtl/ring_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ring_ptr_ctrl
//  Description : Head/tail/count bookkeeping for a SIZE-slot ring of in-order
//                entries. Slots are allocated at the tail, released oldest
//                first at the head, can be truncated back to a given slot
//                (rollback) or dropped entirely (flush).
//                Priority: flush > rollback > alloc; free combines with
//                rollback and with alloc.
//  Ports       : clk            clock, all state on rising edge
//                reset          synchronous active-low reset
//                alloc_call     request to allocate the tail slot
//                alloc_rdy      allocation accepted this cycle if called
//                alloc_idx      slot index that an allocation receives (tail)
//                free_call      request to release the head slot
//                free_rdy       release accepted this cycle if called
//                free_idx       slot index that a release frees (head)
//                rollback_call  discard every slot younger than rollback_idx
//                rollback_idx   youngest slot to keep (must be occupied)
//                flush_call     discard all occupied slots
//                count          occupied slot count (NBITS+1 bits)
//                empty / full   count == 0 / count == SIZE
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_ptr_ctrl
    import ring_ptr_pkg::*;
#(
    parameter int NBITS = RING_DEFAULT_NBITS,
    parameter int SIZE  = RING_DEFAULT_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_call,
    output logic             alloc_rdy,
    output logic [NBITS-1:0] alloc_idx,
    input  logic             free_call,
    output logic             free_rdy,
    output logic [NBITS-1:0] free_idx,
    input  logic             rollback_call,
    input  logic [NBITS-1:0] rollback_idx,
    input  logic             flush_call,
    output logic [NBITS:0]   count,
    output logic             empty,
    output logic             full
);

    localparam int              CNT_W      = ring_cnt_width(NBITS);
    localparam logic [CNT_W-1:0] c_size_cnt = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NBITS-1:0] head_q, head_d;
    logic [NBITS-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // ------------------------------------------------------------------
    // Pointer step helpers
    // ------------------------------------------------------------------
    logic [NBITS-1:0] w_head_inc;
    logic [NBITS-1:0] w_tail_inc;
    logic [NBITS-1:0] w_rb_inc;

    ring_wrap_step #(.NBITS(NBITS), .SIZE(SIZE), .UP(1'b1)) u_head_step (
        .i_val (head_q),
        .o_val (w_head_inc)
    );

    ring_wrap_step #(.NBITS(NBITS), .SIZE(SIZE), .UP(1'b1)) u_tail_step (
        .i_val (tail_q),
        .o_val (w_tail_inc)
    );

    ring_wrap_step #(.NBITS(NBITS), .SIZE(SIZE), .UP(1'b1)) u_rb_step (
        .i_val (rollback_idx),
        .o_val (w_rb_inc)
    );

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_alloc_rdy;
    logic w_free_rdy;
    logic w_alloc_fire;
    logic w_free_fire;

    assign w_empty = (count_q == c_cnt_zero);
    assign w_full  = (count_q == c_size_cnt);

    // alloc_rdy looks only at the registered fullness: a free in the same
    // cycle does not open a slot for an alloc when the ring is full.
    assign w_alloc_rdy  = !w_full && !rollback_call && !flush_call;
    assign w_free_rdy   = !w_empty && !flush_call;
    assign w_alloc_fire = alloc_call && w_alloc_rdy;
    assign w_free_fire  = free_call && w_free_rdy;

    // ------------------------------------------------------------------
    // Rollback distance: (rollback_idx - head) mod SIZE, evaluated in
    // CNT_W bits so a non-power-of-two SIZE wraps correctly. When
    // rollback_idx < head the occupied range wraps past SIZE-1, so SIZE is
    // added before subtracting; the sum stays below 2^CNT_W.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_rb_ext;
    logic [CNT_W-1:0] w_head_ext;
    logic [CNT_W-1:0] w_dist;
    logic [CNT_W-1:0] w_free_ext;

    assign w_rb_ext   = {1'b0, rollback_idx};
    assign w_head_ext = {1'b0, head_q};
    assign w_dist     = (rollback_idx >= head_q) ? (w_rb_ext - w_head_ext)
                                                 : (w_rb_ext + c_size_cnt - w_head_ext);
    assign w_free_ext = {{NBITS{1'b0}}, w_free_fire};

    // ------------------------------------------------------------------
    // Update-path selection (priority flush > rollback > alloc/free)
    // ------------------------------------------------------------------
    ring_op_e w_op;

    always_comb begin
        w_op = RING_OP_HOLD;
        if (flush_call) begin
            w_op = RING_OP_FLUSH;
        end else if (rollback_call) begin
            w_op = RING_OP_ROLLBACK;
        end else if (w_alloc_fire || w_free_fire) begin
            w_op = RING_OP_STEP;
        end
    end

    // ------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (w_op)
            RING_OP_FLUSH: begin
                head_d  = tail_q;
                count_d = c_cnt_zero;
            end
            RING_OP_ROLLBACK: begin
                // Keep head..rollback_idx inclusive, minus the head slot if
                // it is released in the same cycle.
                tail_d  = w_rb_inc;
                count_d = w_dist + c_cnt_one - w_free_ext;
                if (w_free_fire) begin
                    head_d = w_head_inc;
                end
            end
            RING_OP_STEP: begin
                if (w_alloc_fire) begin
                    tail_d = w_tail_inc;
                end
                if (w_free_fire) begin
                    head_d = w_head_inc;
                end
                if (w_alloc_fire && !w_free_fire) begin
                    count_d = count_q + c_cnt_one;
                end else if (w_free_fire && !w_alloc_fire) begin
                    count_d = count_q - c_cnt_one;
                end
            end
            default: begin
                head_d  = head_q;
                tail_d  = tail_q;
                count_d = count_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alloc_rdy = w_alloc_rdy;
    assign free_rdy  = w_free_rdy;
    assign alloc_idx = tail_q;
    assign free_idx  = head_q;
    assign count     = count_q;
    assign empty     = w_empty;
    assign full      = w_full;

endmodule : ring_ptr_ctrl
`default_nettype wire

// File: tb/tb_ring_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_ptr_ctrl
//  Description : Directed, table-driven bench for ring_ptr_ctrl (SIZE=4).
//                Each record gives the inputs for one cycle, the expected
//                ready outputs before the edge and the expected head, tail
//                and count after it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_ptr_ctrl;

    localparam int NBITS = 2;
    localparam int SIZE  = 4;

    logic             clk;
    logic             reset;
    logic             alloc_call;
    logic             alloc_rdy;
    logic [NBITS-1:0] alloc_idx;
    logic             free_call;
    logic             free_rdy;
    logic [NBITS-1:0] free_idx;
    logic             rollback_call;
    logic [NBITS-1:0] rollback_idx;
    logic             flush_call;
    logic [NBITS:0]   count;
    logic             empty;
    logic             full;

    ring_ptr_ctrl #(.NBITS(NBITS), .SIZE(SIZE)) dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_call    (alloc_call),
        .alloc_rdy     (alloc_rdy),
        .alloc_idx     (alloc_idx),
        .free_call     (free_call),
        .free_rdy      (free_rdy),
        .free_idx      (free_idx),
        .rollback_call (rollback_call),
        .rollback_idx  (rollback_idx),
        .flush_call    (flush_call),
        .count         (count),
        .empty         (empty),
        .full          (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst_n;
        bit       alloc;
        bit       free;
        bit       rb;
        bit [1:0] rb_idx;
        bit       flush;
        bit       chk_rdy;
        bit       exp_alloc_rdy;
        bit       exp_free_rdy;
        bit [1:0] exp_head;
        bit [1:0] exp_tail;
        bit [2:0] exp_count;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic add(input bit r, input bit a, input bit f, input bit rb,
                       input int ri, input bit fl, input bit ck,
                       input bit ear, input bit efr,
                       input int h, input int t, input int c);
        vec_t v;
        v.rst_n = r;  v.alloc = a;  v.free = f;  v.rb = rb;
        v.rb_idx = 2'(ri);  v.flush = fl;  v.chk_rdy = ck;
        v.exp_alloc_rdy = ear;  v.exp_free_rdy = efr;
        v.exp_head = 2'(h);  v.exp_tail = 2'(t);  v.exp_count = 3'(c);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit a, input bit f, input bit rb,
                         input bit [1:0] ri, input bit fl);
        reset = r;  alloc_call = a;  free_call = f;
        rollback_call = rb;  rollback_idx = ri;  flush_call = fl;
    endtask

    task automatic check_state(input int idx, input bit [1:0] h,
                               input bit [1:0] t, input bit [2:0] c);
        check("free_idx",  idx, 32'(free_idx),  32'(h));
        check("alloc_idx", idx, 32'(alloc_idx), 32'(t));
        check("count",     idx, 32'(count),     32'(c));
        check("empty",     idx, 32'(empty),     32'(c == 3'd0));
        check("full",      idx, 32'(full),      32'(c == 3'(SIZE)));
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        //   rst a f rb ri fl ck ar fr  h  t  c
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // reset
        // four allocs from reset: alloc_idx 0,1,2,3 then full
        add(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 2, 2);
        add(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 3, 3);
        add(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 4);
        // full: alloc+free -> only the free fires
        add(1, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 3);
        // simultaneous alloc+free below full: count holds, both advance
        add(1, 1, 1, 0, 0, 0, 1, 1, 1, 2, 1, 3);
        add(1, 1, 1, 0, 0, 0, 1, 1, 1, 3, 2, 3);
        add(1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 3, 3);
        // drain to head=3, tail=3, empty
        add(1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 3, 2);
        add(1, 0, 1, 0, 0, 0, 1, 1, 1, 2, 3, 1);
        add(1, 0, 1, 0, 0, 0, 1, 1, 1, 3, 3, 0);
        // free while empty changes nothing
        add(1, 0, 1, 0, 0, 0, 1, 1, 0, 3, 3, 0);
        // wrap: alloc 3 then 0, free 3 then 0
        add(1, 1, 0, 0, 0, 0, 1, 1, 0, 3, 0, 1);
        add(1, 1, 0, 0, 0, 0, 1, 1, 1, 3, 1, 2);
        add(1, 0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 1);
        add(1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0);
        // reset mid-stream with an alloc pending
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        // fill slots 0..3, then rollback to slot 1
        add(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 2, 2);
        add(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 3, 3);
        add(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 4);
        add(1, 1, 0, 1, 1, 0, 1, 0, 1, 0, 2, 2);   // alloc blocked by rollback
        // reach head=2, count=2, then rollback to 2 with a free
        add(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 3, 3);
        add(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 4);
        add(1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 3);
        add(1, 0, 1, 0, 0, 0, 1, 1, 1, 2, 0, 2);
        add(1, 0, 1, 1, 2, 0, 1, 0, 1, 3, 3, 0);
        // wrapped rollback: slots 3,0,1 occupied, keep 3,0
        add(1, 1, 0, 0, 0, 0, 1, 1, 0, 3, 0, 1);
        add(1, 1, 0, 0, 0, 0, 1, 1, 1, 3, 1, 2);
        add(1, 1, 0, 0, 0, 0, 1, 1, 1, 3, 2, 3);
        add(1, 0, 0, 1, 0, 0, 1, 0, 1, 3, 1, 2);
        // flush with rollback, alloc and free all asserted
        add(1, 1, 1, 1, 3, 1, 1, 0, 0, 1, 1, 0);
        add(1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 2, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].alloc, vecs[i].free, vecs[i].rb,
                  vecs[i].rb_idx, vecs[i].flush);
            #1;
            if (vecs[i].chk_rdy) begin
                check("alloc_rdy", i, 32'(alloc_rdy), 32'(vecs[i].exp_alloc_rdy));
                check("free_rdy",  i, 32'(free_rdy),  32'(vecs[i].exp_free_rdy));
            end
            @(posedge clk);
            #1;
            check_state(i, vecs[i].exp_head, vecs[i].exp_tail, vecs[i].exp_count);
        end

        // Hand sequence: reset asserted together with every call; nothing
        // partial survives and the post-reset handshake state is clean.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1);
        @(posedge clk);
        #1;
        check_state(100, 2'd0, 2'd0, 3'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        #1;
        check("alloc_rdy_post_rst", 101, 32'(alloc_rdy), 32'd1);
        check("free_rdy_post_rst",  101, 32'(free_rdy),  32'd0);

        // Hand sequence: alloc while full is ignored across several cycles.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
            @(posedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
            #1;
            check("alloc_rdy_full", 102 + k, 32'(alloc_rdy), 32'd0);
            @(posedge clk);
            #1;
            check_state(102 + k, 2'd0, 2'd0, 3'd4);
        end

        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ring_ptr_ctrl
`default_nettype wire

// File: doc/ring_ptr_ctrl.md
RING_PTR_CTRL -- requirements
Module: ring_ptr_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default 2, meaning slot index width.
REQ-002 SHALL have parameter SIZE, default 4, meaning ring slot count; legal range 2..2^NBITS, any value, not only powers of two.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
REQ-005 SHALL have ports alloc_call (input, 1), alloc_rdy (output, 1), alloc_idx (output, NBITS): allocate the slot at the tail.
REQ-006 SHALL have ports free_call (input, 1), free_rdy (output, 1), free_idx (output, NBITS): release the slot at the head, oldest first.
REQ-007 SHALL have ports rollback_call (input, 1) and rollback_idx (input, NBITS): discard every slot younger than rollback_idx.
REQ-008 SHALL have port flush_call, input, 1 bit: discard all occupied slots.
REQ-009 SHALL have ports count (output, NBITS+1), empty (output, 1) and full (output, 1) for occupancy status.

Function
REQ-010 SHALL hold registers head, tail (NBITS each) and count (NBITS+1); empty = (count==0); full = (count==SIZE).
REQ-011 SHALL drive alloc_idx = tail and free_idx = head combinationally, with zero latency.
REQ-012 SHALL drive alloc_rdy = !full && !rollback_call && !flush_call; a same-cycle free SHALL NOT make alloc_rdy true when full.
REQ-013 SHALL drive free_rdy = !empty && !flush_call.
REQ-014 SHALL treat an operation as fired only when its call and rdy are both 1; a call without rdy SHALL change no state.
REQ-015 SHALL, on an alloc fire, set tail <= wrap_inc(tail), where wrap_inc(x) = (x==SIZE-1) ? 0 : x+1, and increment count.
REQ-016 SHALL, on a free fire, set head <= wrap_inc(head) and decrement count.
REQ-017 SHALL, on a same-cycle alloc fire and free fire, advance both pointers and leave count unchanged.
REQ-018 SHALL, on rollback_call with flush_call==0, set tail <= wrap_inc(rollback_idx) and count <= ((rollback_idx - head) mod SIZE) + 1 - (free fire ? 1 : 0); when free fires, head also advances.
REQ-019 SHALL leave the result of a rollback unspecified when rollback_idx is not an occupied slot; the bench SHALL NOT drive this case.
REQ-020 SHALL, on flush_call, set head <= tail and count <= 0, overriding every other input that cycle.
REQ-021 SHALL apply the priority flush > rollback > alloc; free may combine with rollback (REQ-018) and with alloc (REQ-017).
REQ-022 SHALL compute all modular distances in NBITS+1 bits with no reliance on power-of-two wrap.

Reset
REQ-023 SHALL, when reset==0 at a clk edge, set head=0, tail=0 and count=0, overriding all calls.
REQ-024 SHALL, in the cycle after reset, present alloc_rdy=1, free_rdy=0, empty=1, full=0, alloc_idx=0 and free_idx=0.
REQ-025 SHALL discard any operation in progress when reset is asserted mid-operation; no partial updates.

Structure
REQ-026 SHALL place the default NBITS/SIZE constants and the wrap_inc/wrap_dec distance helpers' width constants in shared package ring_ptr_pkg.
REQ-027 SHALL instantiate sub-module ring_wrap_step (parameters NBITS, SIZE, UP) for each pointer advance; UP=1 wraps SIZE-1 to 0, UP=0 wraps 0 to SIZE-1.
REQ-028 SHALL keep all control logic in ring_ptr_ctrl, with no FSM beyond the head/tail/count registers.

Verification (SIZE=4)
REQ-029 SHALL cover: 4 allocs from reset -> alloc_idx 0,1,2,3; then full=1, alloc_rdy=0, count=4.
REQ-030 SHALL cover: from full, alloc_call+free_call in the same cycle -> only the free fires; head=1, count=3.
REQ-031 SHALL cover: head=3, tail=3, count=0, then 2 allocs -> alloc_idx 3 then 0, tail wraps to 1; 2 frees -> free_idx 3 then 0, empty=1.
REQ-032 SHALL cover: head=0 with slots 0..3 occupied, rollback_idx=1 -> tail=2, count=2, alloc_rdy=0 during the rollback cycle.
REQ-033 SHALL cover: head=2, count=2, rollback_idx=2 with a same-cycle free -> head=3, tail=3, count=0, empty=1.
REQ-034 SHALL cover: flush_call together with rollback_call and alloc_call -> head=tail, count=0, neither alloc nor rollback applied; reset=0 mid-stream -> all registers 0 on the next cycle.
